line_sum_accumulators_line: RTL and testbench

// - Accumulates per-line sums for template matching: sum(I^2), sum(I) and one sum(T_j*I) per template.
// - Each clock adds the current line sums into running totals over the frame/window of NUM_OF_LINES lines.
// - Sits after the per-line sum stage; outputs feed the normalised-correlation stage.

---
 rtl/line_sum_accumulators_line_pkg.sv | 10 +
 rtl/line_sum_acc_reg.sv | 21 ++
 rtl/line_sum_accumulators_line.sv | 28 ++
 tb/tb_line_sum_accumulators_line.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/line_sum_accumulators_line_pkg.sv
// Shared sizing for the line-sum accumulator stage of the template matcher.
// ACC_W leaves log2(NUM_OF_LINES) bits of headroom over a single line sum.
package line_sum_accumulators_line_pkg;
  localparam int PIXEL_SIZE    = 8;
  localparam int LINE_SIZE     = 32;
  localparam int NUM_OF_LINES  = 32;
  localparam int NUM_TEMPLATES = 4;
  localparam int IN_W          = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE;
  localparam int ACC_W         = $clog2(NUM_OF_LINES) + IN_W;
endpackage

// File: rtl/line_sum_acc_reg.sv
// One accumulator channel: adds the zero-extended line sum every edge, wraps mod 2^ACC_W.
module line_sum_acc_reg #(
  parameter int IN_W  = 21,
  parameter int ACC_W = 26
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [IN_W-1:0]  in,
  output logic [ACC_W-1:0] acc
);
  logic [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q + ACC_W'(in);
    if (reset) acc_d = '0;
  end

  always_ff @(posedge CLK) acc_q <= acc_d;

  assign acc = acc_q;
endmodule

// File: rtl/line_sum_accumulators_line.sv
// Running totals of sum(I^2), sum(I) and per-template sum(T_j*I) over a window of lines.
module line_sum_accumulators_line
  import line_sum_accumulators_line_pkg::*;
(
  input  logic             CLK,
  input  logic             reset,
  input  logic [IN_W-1:0]  I_square_out_line_sum,
  input  logic [IN_W-1:0]  I_out_line_sum,
  input  logic [IN_W-1:0]  T_x_I_out_lines_sum [NUM_TEMPLATES],
  output logic [ACC_W-1:0] Acc_lines_sum_I_square,
  output logic [ACC_W-1:0] Acc_lines_sum_I,
  output logic [ACC_W-1:0] Acc_lines_sum_T_x_I_out_lines_sum [NUM_TEMPLATES]
);
  line_sum_acc_reg #(.IN_W(IN_W), .ACC_W(ACC_W)) u_acc_i2 (
    .CLK(CLK), .reset(reset), .in(I_square_out_line_sum), .acc(Acc_lines_sum_I_square)
  );

  line_sum_acc_reg #(.IN_W(IN_W), .ACC_W(ACC_W)) u_acc_i (
    .CLK(CLK), .reset(reset), .in(I_out_line_sum), .acc(Acc_lines_sum_I)
  );

  for (genvar j = 0; j < NUM_TEMPLATES; j++) begin : g_tpl
    line_sum_acc_reg #(.IN_W(IN_W), .ACC_W(ACC_W)) u_acc_t (
      .CLK(CLK), .reset(reset), .in(T_x_I_out_lines_sum[j]),
      .acc(Acc_lines_sum_T_x_I_out_lines_sum[j])
    );
  end
endmodule

// File: tb/tb_line_sum_accumulators_line.sv
// Scoreboard bench: driver pushes expected totals per edge, monitor checks at the falling edge.
module tb_line_sum_accumulators_line;
  import line_sum_accumulators_line_pkg::*;

  typedef logic [NUM_TEMPLATES-1:0][IN_W-1:0]  tin_t;
  typedef logic [NUM_TEMPLATES-1:0][ACC_W-1:0] tacc_t;
  typedef struct packed {
    logic [ACC_W-1:0] i2;
    logic [ACC_W-1:0] i;
    tacc_t            t;
  } exp_t;

  localparam logic [IN_W-1:0] MAXIN = {IN_W{1'b1}};

  logic             CLK = 1'b0;
  logic             reset;
  logic [IN_W-1:0]  i2_in, i_in;
  logic [IN_W-1:0]  t_in [NUM_TEMPLATES];
  logic [ACC_W-1:0] acc_i2, acc_i;
  logic [ACC_W-1:0] acc_t [NUM_TEMPLATES];

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  line_sum_accumulators_line dut (
    .CLK(CLK), .reset(reset),
    .I_square_out_line_sum(i2_in), .I_out_line_sum(i_in),
    .T_x_I_out_lines_sum(t_in),
    .Acc_lines_sum_I_square(acc_i2), .Acc_lines_sum_I(acc_i),
    .Acc_lines_sum_T_x_I_out_lines_sum(acc_t)
  );

  always #5 CLK = ~CLK;

  function automatic tin_t mk_t(input logic [IN_W-1:0] a0, a1, a2, a3);
    mk_t = {a3, a2, a1, a0};
  endfunction

  function automatic tacc_t mk_e(input logic [ACC_W-1:0] a0, a1, a2, a3);
    mk_e = {a3, a2, a1, a0};
  endfunction

  // Drive one edge, then post the totals expected right after that edge.
  task automatic cyc(input bit rst, input logic [IN_W-1:0] a, b, input tin_t t,
                     input logic [ACC_W-1:0] ea, eb, input tacc_t et);
    exp_t e;
    reset = rst; i2_in = a; i_in = b;
    for (int j = 0; j < NUM_TEMPLATES; j++) t_in[j] = t[j];
    @(posedge CLK);
    e.i2 = ea; e.i = eb; e.t = et;
    q.push_back(e);
    #1;
  endtask

  task automatic chk(input string name, input logic [ACC_W-1:0] act, exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("acc_i_square", acc_i2, e.i2);
      chk("acc_i", acc_i, e.i);
      for (int j = 0; j < NUM_TEMPLATES; j++) chk($sformatf("acc_t[%0d]", j), acc_t[j], e.t[j]);
    end
  end

  initial begin
    logic [ACC_W-1:0] m_i2, m_i;
    tacc_t            m_t;
    tin_t             r_t;
    logic [IN_W-1:0]  r_a, r_b;
    longint           big;
    bit               rr;
    int               k;

    reset = 1'b0; i2_in = '0; i_in = '0;
    for (int j = 0; j < NUM_TEMPLATES; j++) t_in[j] = '0;
    repeat (2) @(posedge CLK);
    #1;

    // reset with random inputs
    cyc(1, IN_W'($urandom), IN_W'($urandom),
        mk_t(IN_W'($urandom), IN_W'($urandom), IN_W'($urandom), IN_W'($urandom)),
        0, 0, mk_e(0, 0, 0, 0));

    // basic I channel
    cyc(0, 0, 10, mk_t(0, 0, 0, 0), 0, 10, mk_e(0, 0, 0, 0));
    cyc(0, 0, 20, mk_t(0, 0, 0, 0), 0, 30, mk_e(0, 0, 0, 0));
    cyc(0, 0, 30, mk_t(0, 0, 0, 0), 0, 60, mk_e(0, 0, 0, 0));

    // templates j+1 plus I^2 = 5
    cyc(1, 0, 0, mk_t(0, 0, 0, 0), 0, 0, mk_e(0, 0, 0, 0));
    cyc(0, 5, 0, mk_t(1, 2, 3, 4), 5,  0, mk_e(1, 2, 3, 4));
    cyc(0, 5, 0, mk_t(1, 2, 3, 4), 10, 0, mk_e(2, 4, 6, 8));
    cyc(0, 5, 0, mk_t(1, 2, 3, 4), 15, 0, mk_e(3, 6, 9, 12));
    cyc(0, 5, 0, mk_t(1, 2, 3, 4), 20, 0, mk_e(4, 8, 12, 16));

    // mid-run reset with inputs held at 255
    cyc(1, 255, 255, mk_t(255, 255, 255, 255), 0, 0, mk_e(0, 0, 0, 0));
    cyc(0, 255, 255, mk_t(255, 255, 255, 255), 255, 255, mk_e(255, 255, 255, 255));
    cyc(0, 255, 255, mk_t(255, 255, 255, 255), 510, 510, mk_e(510, 510, 510, 510));
    cyc(1, 255, 255, mk_t(255, 255, 255, 255), 0, 0, mk_e(0, 0, 0, 0));
    cyc(0, 255, 255, mk_t(255, 255, 255, 255), 255, 255, mk_e(255, 255, 255, 255));

    // headroom: NUM_OF_LINES maximal lines fit exactly, one more wraps
    cyc(1, 0, 0, mk_t(0, 0, 0, 0), 0, 0, mk_e(0, 0, 0, 0));
    for (k = 1; k <= NUM_OF_LINES + 1; k++) begin
      logic [ACC_W-1:0] ex;
      big = longint'(k) * ((longint'(1) << IN_W) - 1);
      ex  = ACC_W'(big);
      cyc(0, MAXIN, MAXIN, mk_t(MAXIN, MAXIN, MAXIN, MAXIN), ex, ex, mk_e(ex, ex, ex, ex));
    end
    // 33*(2^21-1) mod 2^26 = 2^21 - 33
    m_i2 = ACC_W'((longint'(1) << IN_W) - 33);
    m_i  = m_i2;
    m_t  = mk_e(m_i2, m_i2, m_i2, m_i2);

    // random 0..255 with reset on cycle 2
    for (int c = 0; c < 10; c++) begin
      rr  = (c == 2);
      r_a = IN_W'($urandom_range(255));
      r_b = IN_W'($urandom_range(255));
      for (int j = 0; j < NUM_TEMPLATES; j++) r_t[j] = IN_W'($urandom_range(255));
      if (rr) begin
        m_i2 = '0; m_i = '0; m_t = '0;
      end else begin
        m_i2 = m_i2 + ACC_W'(r_a);
        m_i  = m_i + ACC_W'(r_b);
        for (int j = 0; j < NUM_TEMPLATES; j++) m_t[j] = m_t[j] + ACC_W'(r_t[j]);
      end
      cyc(rr, r_a, r_b, r_t, m_i2, m_i, m_t);
    end

    reset = 1'b0;
    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge CLK);
    @(posedge CLK);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries unchecked, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
